// File: rtl/id40048008_conv_pkg.sv
// Shared constants and types for the id40048008_conv convolution accelerator.
// Covers bus codes, STATUS layout, geometry and FSM encoding.
package id40048008_conv_pkg;

  localparam int unsigned DATAWIDTH    = 32;
  localparam int unsigned MEMX_DEPTH   = 32;
  localparam int unsigned MEMY_DEPTH   = 32;
  localparam int unsigned MEMOUT_DEPTH = 64;
  localparam int unsigned AX_W         = $clog2(MEMX_DEPTH);
  localparam int unsigned AY_W         = $clog2(MEMY_DEPTH);
  localparam int unsigned AO_W         = $clog2(MEMOUT_DEPTH);
  localparam int unsigned SZ_W         = 5;
  localparam int unsigned CODE_W       = 5;

  localparam logic [CODE_W-1:0] CODE_MDATAINX = 5'd0;
  localparam logic [CODE_W-1:0] CODE_ADATAINX = 5'd1;
  localparam logic [CODE_W-1:0] CODE_MDATAINY = 5'd2;
  localparam logic [CODE_W-1:0] CODE_ADATAINY = 5'd3;
  localparam logic [CODE_W-1:0] CODE_MDATAOUT = 5'd4;
  localparam logic [CODE_W-1:0] CODE_ADATAOUT = 5'd5;
  localparam logic [CODE_W-1:0] CODE_DCONFIG  = 5'd6;
  localparam logic [CODE_W-1:0] CODE_ACONFIG  = 5'd7;
  localparam logic [CODE_W-1:0] CODE_STATUS   = 5'd30;
  localparam logic [CODE_W-1:0] CODE_IP_ID    = 5'd31;

  localparam int unsigned STAT_MASK_LSB = 16;
  localparam int unsigned STAT_BUSY_BIT = 8;
  localparam int unsigned STAT_DONE_BIT = 0;

  localparam logic [DATAWIDTH-1:0] IP_ID_VALUE = 32'h4004_8008;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_MAC   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/id40048008_conv_if.sv
// AIP host port: config-bus select, data in/out, strobes, start and interrupt.
interface id40048008_conv_if;
  import id40048008_conv_pkg::*;

  logic [DATAWIDTH-1:0] data_in;
  logic [DATAWIDTH-1:0] data_out;
  logic                 write;
  logic                 read;
  logic                 start;
  logic [CODE_W-1:0]    conf_dbus;
  logic                 int_req;

  modport master (output data_in, write, read, start, conf_dbus,
                  input  data_out, int_req);
  modport slave  (input  data_in, write, read, start, conf_dbus,
                  output data_out, int_req);
endinterface

// File: rtl/id40048008_conv_core.sv
// Convolution engine: clears the output window, then runs one MAC per cycle
// over every (i, j) pair, read-modify-writing out[i+j].
module id40048008_conv_core
  import id40048008_conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [SZ_W-1:0]      sx,
  input  logic [SZ_W-1:0]      sy,
  input  logic [DATAWIDTH-1:0] x_rdata,
  input  logic [DATAWIDTH-1:0] y_rdata,
  input  logic [DATAWIDTH-1:0] out_rdata,
  output logic [AX_W-1:0]      x_addr_c,
  output logic [AY_W-1:0]      y_addr_c,
  output logic [AO_W-1:0]      out_addr_c,
  output logic                 out_we_c,
  output logic [DATAWIDTH-1:0] out_wdata_c,
  output logic                 busy_c,
  output logic                 done_c
);

  state_t            state_q, state_d;
  logic [AO_W-1:0]   cnt_q, cnt_d;
  logic [SZ_W-1:0]   i_q, i_d, j_q, j_d;
  logic [SZ_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [AO_W-1:0]   clear_last;

  // Sizes are latched at start so a host DCONFIG write cannot disturb a run.
  assign clear_last = AO_W'(sx_q) + AO_W'(sy_q) - AO_W'(2);
  assign x_addr_c   = AX_W'(i_q);
  assign y_addr_c   = AY_W'(j_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    out_addr_c  = AO_W'(i_q) + AO_W'(j_q);
    out_we_c    = 1'b0;
    out_wdata_c = out_rdata + x_rdata * y_rdata;
    busy_c      = (state_q == ST_CLEAR) || (state_q == ST_MAC);
    done_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && start) begin
          sx_d    = sx;
          sy_d    = sy;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = (sx == '0 || sy == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        out_addr_c  = cnt_q;
        out_wdata_c = '0;
        out_we_c    = en;
        if (en) begin
          if (cnt_q == clear_last) state_d = ST_MAC;
          else                     cnt_d   = cnt_q + AO_W'(1);
        end
      end
      ST_MAC: begin
        out_we_c = en;
        if (en) begin
          if (j_q == sy_q - SZ_W'(1)) begin
            j_d = '0;
            if (i_q == sx_q - SZ_W'(1)) state_d = ST_DONE;
            else                        i_d     = i_q + SZ_W'(1);
          end else begin
            j_d = j_q + SZ_W'(1);
          end
        end
      end
      ST_DONE: begin
        done_c = en;
        if (en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

endmodule

// File: rtl/id40048008_conv.sv
// AIP wrapper: pointer/config/status registers, the X/Y/OUT memories and the
// registered read port in front of the convolution core.
module id40048008_conv
  import id40048008_conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_a,
  input  logic               en_s,
  id40048008_conv_if.slave   aip
);

  logic [DATAWIDTH-1:0] x_mem   [MEMX_DEPTH];
  logic [DATAWIDTH-1:0] y_mem   [MEMY_DEPTH];
  logic [DATAWIDTH-1:0] out_mem [MEMOUT_DEPTH];

  logic [AX_W-1:0]      ptr_x_q, ptr_x_d;
  logic [AY_W-1:0]      ptr_y_q, ptr_y_d;
  logic [AO_W-1:0]      ptr_o_q, ptr_o_d;
  logic [2*SZ_W-1:0]    dconfig_q, dconfig_d;
  logic [7:0]           mask_q, mask_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] data_out_q, data_out_d;
  logic                 int_req_q, int_req_d;
  logic [DATAWIDTH-1:0] rdata_c;
  logic                 wr_c, rd_c, acc_c;

  logic [AX_W-1:0]      core_x_addr;
  logic [AY_W-1:0]      core_y_addr;
  logic [AO_W-1:0]      core_o_addr;
  logic                 core_we, core_busy, core_done;
  logic [DATAWIDTH-1:0] core_wdata;

  assign wr_c  = en_s & aip.write;
  assign rd_c  = en_s & aip.read;
  assign acc_c = wr_c | rd_c;

  id40048008_conv_core u_core (
    .clk         (clk),
    .rst         (rst_a),
    .en          (en_s),
    .start       (aip.start),
    .sx          (dconfig_q[SZ_W-1:0]),
    .sy          (dconfig_q[2*SZ_W-1:SZ_W]),
    .x_rdata     (x_mem[core_x_addr]),
    .y_rdata     (y_mem[core_y_addr]),
    .out_rdata   (out_mem[core_o_addr]),
    .x_addr_c    (core_x_addr),
    .y_addr_c    (core_y_addr),
    .out_addr_c  (core_o_addr),
    .out_we_c    (core_we),
    .out_wdata_c (core_wdata),
    .busy_c      (core_busy),
    .done_c      (core_done)
  );

  // Register-file decode and read mux; memory accesses post-increment the pointer.
  always_comb begin
    ptr_x_d    = ptr_x_q;
    ptr_y_d    = ptr_y_q;
    ptr_o_d    = ptr_o_q;
    dconfig_d  = dconfig_q;
    mask_d     = mask_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    rdata_c    = '0;
    case (aip.conf_dbus)
      CODE_MDATAINX: begin
        rdata_c = x_mem[ptr_x_q];
        if (acc_c) ptr_x_d = ptr_x_q + AX_W'(1);
      end
      CODE_ADATAINX: begin
        rdata_c = DATAWIDTH'(ptr_x_q);
        if (wr_c) ptr_x_d = aip.data_in[AX_W-1:0];
      end
      CODE_MDATAINY: begin
        rdata_c = y_mem[ptr_y_q];
        if (acc_c) ptr_y_d = ptr_y_q + AY_W'(1);
      end
      CODE_ADATAINY: begin
        rdata_c = DATAWIDTH'(ptr_y_q);
        if (wr_c) ptr_y_d = aip.data_in[AY_W-1:0];
      end
      CODE_MDATAOUT: begin
        rdata_c = out_mem[ptr_o_q];
        if (acc_c) ptr_o_d = ptr_o_q + AO_W'(1);
      end
      CODE_ADATAOUT: begin
        rdata_c = DATAWIDTH'(ptr_o_q);
        if (wr_c) ptr_o_d = aip.data_in[AO_W-1:0];
      end
      CODE_DCONFIG: begin
        rdata_c = DATAWIDTH'(dconfig_q);
        if (wr_c) dconfig_d = aip.data_in[2*SZ_W-1:0];
      end
      CODE_STATUS: begin
        rdata_c[STAT_MASK_LSB +: 8] = mask_q;
        rdata_c[STAT_BUSY_BIT]      = core_busy;
        rdata_c[STAT_DONE_BIT]      = done_q;
        if (wr_c) begin
          mask_d = aip.data_in[STAT_MASK_LSB +: 8];
          done_d = done_q & ~aip.data_in[STAT_DONE_BIT];
        end
      end
      CODE_IP_ID: rdata_c = IP_ID_VALUE;
      default:    rdata_c = '0;
    endcase
    if (core_done) done_d = 1'b1;
    if (rd_c) data_out_d = rdata_c;
    int_req_d = ~(done_d & mask_d[0]);
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ptr_x_q    <= '0;
      ptr_y_q    <= '0;
      ptr_o_q    <= '0;
      dconfig_q  <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      int_req_q  <= 1'b1;
    end else begin
      ptr_x_q    <= ptr_x_d;
      ptr_y_q    <= ptr_y_d;
      ptr_o_q    <= ptr_o_d;
      dconfig_q  <= dconfig_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      int_req_q  <= int_req_d;
    end
  end

  // Memories are not reset; the core owns the OUT write port while it writes.
  always_ff @(posedge clk) begin
    if (wr_c && aip.conf_dbus == CODE_MDATAINX) x_mem[ptr_x_q] <= aip.data_in;
    if (wr_c && aip.conf_dbus == CODE_MDATAINY) y_mem[ptr_y_q] <= aip.data_in;
    if (core_we)                                      out_mem[core_o_addr] <= core_wdata;
    else if (wr_c && aip.conf_dbus == CODE_MDATAOUT) out_mem[ptr_o_q]     <= aip.data_in;
  end

  assign aip.data_out = data_out_q;
  assign aip.int_req  = int_req_q;

endmodule

// File: tb/tb_id40048008_conv.sv
// Scoreboard bench for id40048008_conv: host tasks queue expected read data,
// a monitor compares data_out on the cycle after each accepted read.
module tb_id40048008_conv;
  import id40048008_conv_pkg::*;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic en_s  = 1'b1;

  id40048008_conv_if aip ();

  id40048008_conv dut (
    .clk   (clk),
    .rst_a (rst_a),
    .en_s  (en_s),
    .aip   (aip)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] model_out [64];
  logic [31:0] xv [32];
  logic [31:0] yv [32];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every read accepted on a rising edge is compared just after it.
  initial begin
    logic [31:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      if (!rst_a && en_s && aip.read === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: got %h expected no read", aip.data_out);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, aip.data_out, e);
        end
      end
    end
  end

  task automatic wr(input logic [4:0] code, input logic [31:0] d);
    aip.conf_dbus = code;
    aip.data_in   = d;
    aip.write     = 1'b1;
    @(negedge clk);
    aip.write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] code, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    aip.conf_dbus = code;
    aip.read      = 1'b1;
    @(negedge clk);
    aip.read      = 1'b0;
  endtask

  task automatic load(input int nx, input int ny);
    wr(CODE_ADATAINX, 32'd0);
    for (int k = 0; k < nx; k++) wr(CODE_MDATAINX, xv[k]);
    wr(CODE_ADATAINY, 32'd0);
    for (int k = 0; k < ny; k++) wr(CODE_MDATAINY, yv[k]);
  endtask

  task automatic rd_out(input int n, input string nm);
    wr(CODE_ADATAOUT, 32'd0);
    for (int k = 0; k < n; k++) rd(CODE_MDATAOUT, model_out[k], $sformatf("%s[%0d]", nm, k));
  endtask

  // Updates the reference output, programs DCONFIG, starts and waits for int_req.
  task automatic run(input int sx, input int sy, input string nm);
    int budget;
    int cyc;
    if (sx > 0 && sy > 0) begin
      for (int n = 0; n < sx + sy - 1; n++) model_out[n % 64] = 32'd0;
      for (int i = 0; i < sx; i++)
        for (int j = 0; j < sy; j++)
          model_out[(i + j) % 64] = model_out[(i + j) % 64] + xv[i] * yv[j];
    end
    wr(CODE_DCONFIG, 32'(sx | (sy << 5)));
    rd(CODE_DCONFIG, 32'(sx | (sy << 5)), {nm, "_dconfig"});
    aip.start = 1'b1;
    @(negedge clk);
    aip.start = 1'b0;
    budget = (sx + sy - 1) + sx * sy + 3;
    cyc = 0;
    while (aip.int_req !== 1'b0 && cyc <= budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (aip.int_req === 1'b0 && cyc <= budget) n_pass++;
    else $display("FAIL %s_latency: got int_req=%b after %0d cycles, expected 0 within %0d",
                  nm, aip.int_req, cyc, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    aip.data_in   = '0;
    aip.write     = 1'b0;
    aip.read      = 1'b0;
    aip.start     = 1'b0;
    aip.conf_dbus = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_int_req", 32'(aip.int_req), 32'd1);
    check("rst_data_out", aip.data_out, 32'd0);

    rd(CODE_IP_ID, 32'h4004_8008, "ip_id");
    rd(CODE_STATUS, 32'h0000_0000, "status_rst");
    rd(5'd10, 32'd0, "unmapped");
    wr(CODE_STATUS, 32'h0001_0000);
    rd(CODE_STATUS, 32'h0001_0000, "status_mask");
    check("mask_int_req", 32'(aip.int_req), 32'd1);

    // Hand-computed: [1,2,3] * [1,1] = [1,3,5,3]
    xv[0] = 32'd1; xv[1] = 32'd2; xv[2] = 32'd3;
    yv[0] = 32'd1; yv[1] = 32'd1;
    load(3, 2);
    run(3, 2, "conv3x2");
    rd(CODE_STATUS, 32'h0001_0001, "status_done");
    wr(CODE_ADATAOUT, 32'd0);
    rd(CODE_MDATAOUT, 32'd1, "o3x2[0]");
    rd(CODE_MDATAOUT, 32'd3, "o3x2[1]");
    rd(CODE_MDATAOUT, 32'd5, "o3x2[2]");
    rd(CODE_MDATAOUT, 32'd3, "o3x2[3]");
    rd(CODE_ADATAOUT, 32'd4, "ptr_out");
    wr(CODE_STATUS, 32'h0001_0001);
    rd(CODE_STATUS, 32'h0001_0000, "status_clr");
    check("clr_int_req", 32'(aip.int_req), 32'd1);

    for (int k = 0; k < 5;  k++) xv[k] = 32'($urandom_range(0, 99));
    for (int k = 0; k < 10; k++) yv[k] = 32'($urandom_range(0, 99));
    load(5, 10);
    run(5, 10, "conv5x10");
    rd_out(14, "o5x10");
    wr(CODE_STATUS, 32'h0001_0001);

    xv[0] = 32'hFFFF_FFFF;
    yv[0] = 32'd2;
    load(1, 1);
    run(1, 1, "conv_wrap");
    wr(CODE_ADATAOUT, 32'd0);
    rd(CODE_MDATAOUT, 32'hFFFF_FFFE, "o_wrap");
    wr(CODE_STATUS, 32'h0001_0001);

    run(0, 3, "conv_sx0");
    rd_out(14, "o_sx0");
    wr(CODE_STATUS, 32'h0001_0001);
    check("sx0_clr_int_req", 32'(aip.int_req), 32'd1);

    wr(CODE_ADATAINX, 32'd0);
    en_s = 1'b0;
    wr(CODE_MDATAINX, 32'h0000_DEAD);
    en_s = 1'b1;
    rd(CODE_MDATAINX, 32'hFFFF_FFFF, "en_s_hold");
    rd(CODE_ADATAINX, 32'd1, "ptr_x");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending reads, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id40048008_conv.md
Name: id40048008_conv

Overview:
- AIP-wrapped 1-D linear convolution accelerator.
- Host loads vector X (memory MDATAINX) and vector Y (memory MDATAINY), writes sizes to DCONFIG, pulses start, waits for the active-low interrupt, then reads X*Y from MDATAOUT.
- All access goes through a single 5-bit config-bus / 32-bit data port protocol shared with the team's other AIP cores.

Parameters:
- DATAWIDTH, 32, width of data_in, data_out and all memory words.
- MEMX_DEPTH, 32, words in the X input memory.
- MEMY_DEPTH, 32, words in the Y input memory.
- MEMOUT_DEPTH, 64, words in the output memory.
- IP_ID_VALUE, 32'h4004_8008, value returned on an IP_ID read.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_a  in  1  asynchronous reset, active-high.
- en_s  in  1  synchronous enable; when low, all state holds and write/read/start are ignored.
- data_in  in  32  write data.
- data_out  out  32  read data.
- write  in  1  write strobe; one word is written per clock in which it is high.
- read  in  1  read strobe; one word is read per clock in which it is high.
- start  in  1  starts a convolution; level-sampled on the clock edge.
- conf_dbus  in  5  selects the target of write/read.
- int_req  out  1  interrupt request, active-low.

Behaviour:
- conf_dbus codes:
  - 0 MDATAINX, 1 ADATAINX, 2 MDATAINY, 3 ADATAINY.
  - 4 MDATAOUT, 5 ADATAOUT, 6 DCONFIG, 7 ACONFIG.
  - 30 STATUS, 31 IP_ID.
  - Other codes: writes ignored, reads return 0.
- Pointer registers (odd codes 1/3/5/7):
  - Writing to an odd code loads that target's pointer from data_in (low address bits).
- Memory access (even codes 0/2/4/6), on an edge with write=1 or read=1:
  - Access the word at the target's pointer, then post-increment the pointer.
  - Pointers wrap modulo the memory depth.
- Reads are registered: on an edge with read=1, data_out loads the selected word; otherwise data_out holds.
- Host-side writes to MDATAOUT are accepted.
- DCONFIG is a single register (pointer 0 only):
  - bits [4:0] = SX, the X length.
  - bits [9:5] = SY, the Y length.
  - Reads return the stored value, upper bits 0.
- STATUS read format:
  - [23:16] interrupt mask.
  - [8] busy.
  - [0] done flag.
  - All other bits 0.
- STATUS write:
  - [23:16] replaces the mask.
  - [7:0] is write-1-to-clear on the flags.
  - Flag set by hardware wins over a simultaneous clear.
- IP_ID read returns IP_ID_VALUE; IP_ID writes are ignored.
- int_req = ~|(flags[7:0] & mask[7:0]). Only bit 0 (done) is implemented.
- Computation:
  - Result: out[n] = sum over k of x[k]*y[n-k], for n = 0..SX+SY-2.
  - Products and sums are truncated modulo 2^32 (unsigned).
- FSM states and transitions:
  - IDLE: on start, go to CLEAR; busy=1.
  - CLEAR: zero out[0..SX+SY-2], one word per cycle.
  - MAC: for i in 0..SX-1 and j in 0..SY-1, out[i+j] += x[i]*y[j], one MAC per cycle.
  - DONE: set done flag, busy=0, return to IDLE.
- Latency: start to done ≤ (SX+SY-1) + SX*SY + 3 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - SX=0 or SY=0: go directly to DONE; output memory untouched.
  - SX+SY-1 > MEMOUT_DEPTH: output addresses wrap.
  - Host access to memories while busy is allowed but yields undefined results.
  - Reset mid-operation: FSM returns to IDLE.
- Reset values:
  - All pointers 0, DCONFIG 0, mask 0, flags 0, busy 0.
  - data_out 0, int_req 1, FSM IDLE.
  - Memory contents are not reset.

Decomposition:
- Package id40048008_conv_pkg holds:
  - conf_dbus code constants.
  - STATUS bit positions.
  - IP_ID_VALUE.
  - FSM state typedef.
- One sub-module: id40048008_conv_core, containing the FSM, MAC datapath and memory address generation.
- The top level holds the AIP register/memory interface and the three memories.

Test Plan:
- After reset: IP_ID read = 32'h40048008; STATUS read = 0x00000000; int_req=1.
- Write STATUS 0x00010000 -> STATUS reads 0x00010000, int_req stays 1.
- X=[1,2,3], Y=[1,1], DCONFIG=0x43, start -> int_req falls; STATUS=0x00010001; MDATAOUT reads [1,3,5,3].
- Write STATUS 0x00010001 (clear done) -> STATUS=0x00010000, int_req=1.
- SX=5, SY=10 with random values 0..99 -> 14 outputs match a software convolution model; done within 67 cycles.
- Edge cases:
  - x=[0xFFFFFFFF], y=[2] -> out[0]=0xFFFFFFFE.
  - SX=0 -> done immediately, outputs unchanged.
  - en_s=0 during write -> memory unchanged.
